// File: rtl/tap_controller_pkg.sv
// ---------------------------------------------------------------------------
// tap_controller_pkg
//   Shared constants for the JTAG TAP controller.
//   - STATE_W and the sixteen TAP state encodings. These use the same values
//     as the instruction-register side of the codebase, so the state bus can be
//     decoded directly by instruction_register and the DR chain.
//   - tap_ctrl_t: the registered control strobes that the controller drives.
//   - CTRL_RESET: strobe values while in Test-Logic-Reset.
//   - in_ir_branch(): true for SelIR..UpdIR, which drives the TDO mux select.
// ---------------------------------------------------------------------------
package tap_controller_pkg;

    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] tap_state_t;

    localparam tap_state_t tlr_c      = 4'hF;
    localparam tap_state_t rti_c      = 4'hC;
    localparam tap_state_t seldr_c    = 4'h7;
    localparam tap_state_t capdr_c    = 4'h6;
    localparam tap_state_t shdr_c     = 4'h2;
    localparam tap_state_t exit1dr_c  = 4'h1;
    localparam tap_state_t pausedr_c  = 4'h3;
    localparam tap_state_t exit2dr_c  = 4'h0;
    localparam tap_state_t upddr_c    = 4'h5;
    localparam tap_state_t selir_c    = 4'h4;
    localparam tap_state_t capir_c    = 4'hE;
    localparam tap_state_t shir_c     = 4'hA;
    localparam tap_state_t exit1ir_c  = 4'h9;
    localparam tap_state_t pauseir_c  = 4'hB;
    localparam tap_state_t exit2ir_c  = 4'h8;
    localparam tap_state_t updir_c    = 4'hD;

    // Control strobes registered on falling tck. up_ir/up_dr/tlr_n are active-low.
    typedef struct packed {
        logic sh_ir;
        logic sh_dr;
        logic up_ir;
        logic up_dr;
        logic tlr_n;
        logic sel_ir;
        logic tdo_en;
    } tap_ctrl_t;

    localparam tap_ctrl_t CTRL_RESET = '{
        sh_ir:  1'b0,
        sh_dr:  1'b0,
        up_ir:  1'b1,
        up_dr:  1'b1,
        tlr_n:  1'b0,
        sel_ir: 1'b0,
        tdo_en: 1'b0
    };

    function automatic logic in_ir_branch(input tap_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            selir_c, capir_c, shir_c, exit1ir_c,
            pauseir_c, exit2ir_c, updir_c: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tap_clock_gate.sv
// ---------------------------------------------------------------------------
// tap_clock_gate
//   Glitch-free clock gate: the enable is captured by a latch that is
//   transparent while clk is low, and the output is clk AND the latched enable.
//   An enable change while clk is high therefore cannot chop a pulse.
// Ports:
//   clk   in   free-running clock (tck)
//   en    in   gate enable, may change at any time
//   gclk  out  gated clock
// ---------------------------------------------------------------------------
module tap_clock_gate (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_latched;

    always_latch begin
        if (!clk) begin
            en_latched <= en;
        end
    end

    assign gclk = clk & en_latched;

endmodule

// File: rtl/tap_controller.sv
// ---------------------------------------------------------------------------
// tap_controller
//   IEEE 1149.1 TAP state machine. The state advances on rising tck under tms.
//   The IR/DR control strobes are decoded from the state and registered on
//   falling tck, so they settle half a tck after each state change. The gated
//   IR/DR clocks run only in Capture/Shift of their branch.
//
// Ports:
//   tck        in   test clock; state updates on rising edge
//   reset      in   synchronous, active-low; forces Test-Logic-Reset
//   tms        in   test mode select, sampled on rising tck
//   state      out  current TAP state (tap_controller_pkg encoding)
//   clkIR      out  gated IR clock (Capture-IR / Shift-IR)
//   shIR       out  1 in Shift-IR
//   upIR       out  active-low IR update strobe (Update-IR)
//   clkDR      out  gated DR clock (Capture-DR / Shift-DR)
//   shDR       out  1 in Shift-DR
//   upDR       out  active-low DR update strobe (Update-DR)
//   tlr_n      out  0 while in Test-Logic-Reset
//   sel_ir     out  TDO mux select, 1 in the IR branch
//   tdo_en     out  TDO output enable, 1 in Shift-IR / Shift-DR
//   trace_cnt  out  (TAP_STATE_TRACE_EN only) count of completed IR+DR scans
//
// Build option:
//   TAP_STATE_TRACE_EN  adds trace_cnt[7:0]. It increments on every entry to
//                       Update-IR/Update-DR, wraps at 255, and is cleared
//                       while tlr_n is low.
// ---------------------------------------------------------------------------
module tap_controller
    import tap_controller_pkg::*;
(
    input  logic               tck,
    input  logic               reset,
    input  logic               tms,
    output logic [STATE_W-1:0] state,
    output logic               clkIR,
    output logic               shIR,
    output logic               upIR,
    output logic               clkDR,
    output logic               shDR,
    output logic               upDR,
    output logic               tlr_n,
    output logic               sel_ir,
`ifdef TAP_STATE_TRACE_EN
    output logic               tdo_en,
    output logic [7:0]         trace_cnt
`else
    output logic               tdo_en
`endif
);

    tap_state_t state_q;
    tap_state_t state_d;
    tap_ctrl_t  ctrl_d;
    tap_ctrl_t  ctrl_q;
    logic       ir_gate_en;
    logic       dr_gate_en;

    // ------------------------------------------------------------------
    // State register. Reset takes priority over tms, so a scan in progress
    // is abandoned without passing through an Update state.
    // ------------------------------------------------------------------
    always_ff @(posedge tck) begin
        if (!reset) begin
            state_q <= tlr_c;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            tlr_c:     state_d = tms ? tlr_c     : rti_c;
            rti_c:     state_d = tms ? seldr_c   : rti_c;
            seldr_c:   state_d = tms ? selir_c   : capdr_c;
            capdr_c:   state_d = tms ? exit1dr_c : shdr_c;
            shdr_c:    state_d = tms ? exit1dr_c : shdr_c;
            exit1dr_c: state_d = tms ? upddr_c   : pausedr_c;
            pausedr_c: state_d = tms ? exit2dr_c : pausedr_c;
            exit2dr_c: state_d = tms ? upddr_c   : shdr_c;
            upddr_c:   state_d = tms ? seldr_c   : rti_c;
            selir_c:   state_d = tms ? tlr_c     : capir_c;
            capir_c:   state_d = tms ? exit1ir_c : shir_c;
            shir_c:    state_d = tms ? exit1ir_c : shir_c;
            exit1ir_c: state_d = tms ? updir_c   : pauseir_c;
            pauseir_c: state_d = tms ? exit2ir_c : pauseir_c;
            exit2ir_c: state_d = tms ? updir_c   : shir_c;
            updir_c:   state_d = tms ? seldr_c   : rti_c;
            default:   state_d = tlr_c;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the current state
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d        = CTRL_RESET;
        ctrl_d.tlr_n  = 1'b1;
        ctrl_d.sel_ir = in_ir_branch(state_q);
        ir_gate_en    = 1'b0;
        dr_gate_en    = 1'b0;
        case (state_q)
            tlr_c: begin
                ctrl_d.tlr_n = 1'b0;
            end
            capir_c: begin
                ir_gate_en = 1'b1;
            end
            shir_c: begin
                ctrl_d.sh_ir  = 1'b1;
                ctrl_d.tdo_en = 1'b1;
                ir_gate_en    = 1'b1;
            end
            updir_c: begin
                ctrl_d.up_ir = 1'b0;
            end
            capdr_c: begin
                dr_gate_en = 1'b1;
            end
            shdr_c: begin
                ctrl_d.sh_dr  = 1'b1;
                ctrl_d.tdo_en = 1'b1;
                dr_gate_en    = 1'b1;
            end
            upddr_c: begin
                ctrl_d.up_dr = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Strobes are retimed to falling tck so downstream registers clocked on
    // rising tck see stable controls for the whole high phase.
    always_ff @(negedge tck) begin
        if (!reset) begin
            ctrl_q <= CTRL_RESET;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign state  = state_q;
    assign shIR   = ctrl_q.sh_ir;
    assign shDR   = ctrl_q.sh_dr;
    assign upIR   = ctrl_q.up_ir;
    assign upDR   = ctrl_q.up_dr;
    assign tlr_n  = ctrl_q.tlr_n;
    assign sel_ir = ctrl_q.sel_ir;
    assign tdo_en = ctrl_q.tdo_en;

    // ------------------------------------------------------------------
    // Gated scan clocks. The enable for a state is latched during that
    // state's low phase, so the first pulse is the rising edge that leaves
    // Capture, and the last is the one that leaves Shift.
    // ------------------------------------------------------------------
    tap_clock_gate u_ir_gate (
        .clk  (tck),
        .en   (ir_gate_en),
        .gclk (clkIR)
    );

    tap_clock_gate u_dr_gate (
        .clk  (tck),
        .en   (dr_gate_en),
        .gclk (clkDR)
    );

`ifdef TAP_STATE_TRACE_EN
    logic [7:0] trace_q;
    logic       upd_entry;

    assign upd_entry = ((state_d == updir_c) || (state_d == upddr_c)) &&
                       (state_d != state_q);

    always_ff @(posedge tck) begin
        if (!reset || !ctrl_q.tlr_n) begin
            trace_q <= 8'd0;
        end else if (upd_entry) begin
            trace_q <= trace_q + 8'd1;
        end
    end

    assign trace_cnt = trace_q;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_tap_controller
//   Directed bench for tap_controller. Each step drives tms/reset, pushes the
//   expected {state, strobes} onto exp_q, and pops/compares after the rising
//   edge (state, gated clocks high phase) and the falling edge (strobes,
//   gated clocks low phase). Build with TAP_STATE_TRACE_EN to also check the
//   scan counter and its wrap.
// ---------------------------------------------------------------------------
module tb_tap_controller;

    localparam int TLR_ONES = 5;

    logic       tck;
    logic       reset;
    logic       tms;
    logic [3:0] state;
    logic       clkIR, shIR, upIR, clkDR, shDR, upDR, tlr_n, sel_ir, tdo_en;
`ifdef TAP_STATE_TRACE_EN
    logic [7:0] trace_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    logic [3:0]  prev_st;

    tap_controller dut (
        .tck    (tck),
        .reset  (reset),
        .tms    (tms),
        .state  (state),
        .clkIR  (clkIR),
        .shIR   (shIR),
        .upIR   (upIR),
        .clkDR  (clkDR),
        .shDR   (shDR),
        .upDR   (upDR),
        .tlr_n  (tlr_n),
        .sel_ir (sel_ir),
`ifdef TAP_STATE_TRACE_EN
        .tdo_en (tdo_en),
        .trace_cnt (trace_cnt)
`else
        .tdo_en (tdo_en)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    // Expected strobes {shIR, shDR, upIR, upDR, tlr_n, sel_ir, tdo_en}
    function automatic logic [6:0] exp_ctrl(input logic [3:0] s);
        logic sh_ir, sh_dr, up_ir, up_dr, t_n, sel, en;
        sh_ir = (s == 4'hA);
        sh_dr = (s == 4'h2);
        up_ir = (s != 4'hD);
        up_dr = (s != 4'h5);
        t_n   = (s != 4'hF);
        en    = (s == 4'hA) || (s == 4'h2);
        sel   = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
                (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
        return {sh_ir, sh_dr, up_ir, up_dr, t_n, sel, en};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One tck: drive, push expectation, compare after both edges.
    task automatic step(input logic t, input logic r, input logic [3:0] exp_st);
        logic [10:0] e;
        exp_q.push_back({exp_st, exp_ctrl(exp_st)});
        tms   = t;
        reset = r;
        @(posedge tck);
        #1;
        e = exp_q.pop_front();
        check("state", 32'(state), 32'(e[10:7]));
        check("clkIR_high", 32'(clkIR), 32'((prev_st == 4'hE) || (prev_st == 4'hA)));
        check("clkDR_high", 32'(clkDR), 32'((prev_st == 4'h6) || (prev_st == 4'h2)));
        @(negedge tck);
        #1;
        check("strobes", 32'({shIR, shDR, upIR, upDR, tlr_n, sel_ir, tdo_en}), 32'(e[6:0]));
        check("clk_low", 32'({clkIR, clkDR}), 32'd0);
        prev_st = exp_st;
    endtask

    initial begin
        reset   = 1'b0;
        tms     = 1'b0;
        prev_st = 4'hF;

        // Reset with arbitrary tms, then into Run-Test/Idle
        step(1'($urandom_range(0, 1)), 1'b0, 4'hF);
        step(1'b1, 1'b1, 4'hF);             // TLR holds on tms=1
        step(1'b0, 1'b1, 4'hC);

        // Into Shift-IR, three shift clocks, exit and update
        step(1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'hE);
        step(1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h9);
        step(1'b1, 1'b1, 4'hD);
        step(1'b0, 1'b1, 4'hC);
        step(1'b0, 1'b1, 4'hC);             // RTI holds on tms=0

        // DR scan with a pause loop
        step(1'b1, 1'b1, 4'h7);
        step(1'b0, 1'b1, 4'h6);
        step(1'b0, 1'b1, 4'h2);
        step(1'b1, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'h3);
        step(1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h2);
        step(1'b0, 1'b1, 4'h2);

        // TLR_ONES ones from Shift-DR reach Test-Logic-Reset
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 4'h4);
        step(1'b1, 1'b1, 4'hF);

        // IR pause path, then TLR_ONES ones from Pause-IR
        step(1'b0, 1'b1, 4'hC);
        step(1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'hE);
        step(1'b1, 1'b1, 4'h9);
        step(1'b0, 1'b1, 4'hB);
        step(1'b0, 1'b1, 4'hB);
        step(1'b1, 1'b1, 4'h8);
        step(1'b0, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h9);
        step(1'b0, 1'b1, 4'hB);
        for (int i = 0; i < TLR_ONES; i++) begin
            logic [3:0] walk[5];
            walk = '{4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
            step(1'b1, 1'b1, walk[i]);
        end

        // Reset in the middle of Shift-IR: no Update-IR strobe
        step(1'b0, 1'b1, 4'hC);
        step(1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b1, 4'h4);
        step(1'b0, 1'b1, 4'hE);
        step(1'b0, 1'b1, 4'hA);
        step(1'($urandom_range(0, 1)), 1'b0, 4'hF);
        step(1'b0, 1'b1, 4'hC);

        // Random DR scan lengths
        for (int n = 0; n < 3; n++) begin
            int len;
            len = $urandom_range(1, 6);
            step(1'b1, 1'b1, 4'h7);
            step(1'b0, 1'b1, 4'h6);
            for (int k = 0; k < len; k++) step(1'b0, 1'b1, 4'h2);
            step(1'b1, 1'b1, 4'h1);
            step(1'b1, 1'b1, 4'h5);
            step(1'b0, 1'b1, 4'hC);
        end

`ifdef TAP_STATE_TRACE_EN
        // Counter is cleared in TLR and counts every Update entry, wrapping
        step(1'b0, 1'b0, 4'hF);
        step(1'b0, 1'b1, 4'hC);
        check("trace_clear", 32'(trace_cnt), 32'd0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 4'h7);
            step(1'b0, 1'b1, 4'h6);
            step(1'b1, 1'b1, 4'h1);
            step(1'b1, 1'b1, 4'h5);
            check("trace_cnt", 32'(trace_cnt), 32'((i + 1) % 256));
            step(1'b0, 1'b1, 4'hC);
        end
        check("trace_wrap", 32'(trace_cnt), 32'd0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
